card7seg_bank: RTL
==================

Name: card7seg_bank

Overview:
- Parametrised successor to the single-card 7-segment decoder.
- Holds N_CARDS registered card slots and drives one active-low 7-segment digit per slot.
- A newly dealt card blinks for a programmable number of periods before it goes steady.
- Sits between the Baccarat datapath (load strobes from the dealing FSM) and the DE1-SoC HEX displays.

Parameters:
- N_CARDS, 6: number of card slots and digits.
- IDX_W, 3: width of load_idx; must satisfy 2**IDX_W >= N_CARDS.
- BLINK_DIV, 25000000: clock cycles per blink half-period.
- BLINKS, 2: blank pulses shown after each valid load; 0 disables blinking.

Ports:
- slow_clock  in   1  sole clock; all state updates on the rising edge.
- resetb  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all slots.
- load  in  1  write strobe, one cycle.
- load_idx  in  IDX_W  target slot.
- card_in  in  4  card code: 1=A, 2..10, 11=J, 12=Q, 13=K; 0, 14 and 15 are empty/invalid.
- seg_bus  out  7*N_CARDS  slot i occupies bits [7i+6:7i], ordered {g,f,e,d,c,b,a}, active-low.
- busy  out  1  high while any slot is blinking.

Behaviour:
- State per slot i:
  - card_reg[i], 4 bits.
  - div_cnt[i], wide enough for BLINK_DIV-1.
  - half_left[i], wide enough for 2*BLINKS.
- Reset (resetb low, asynchronous):
  - card_reg=0, div_cnt=0, half_left=0.
  - Hence seg_bus is all ones (every digit blank) and busy=0 immediately, without waiting for a clock edge.
- Priority is clear > load.
- clear=1 at an edge: all slots return to the reset state at that edge; any load in the same cycle is dropped.
- load=1, clear=0 at an edge, load_idx<N_CARDS:
  - card_reg[idx] <= card_in.
  - div_cnt[idx] <= 0.
  - half_left[idx] <= 2*BLINKS if card_in is in 1..13, else 0.
  - This restarts any blink in progress on that slot.
  - Other slots are unaffected.
- load with load_idx>=N_CARDS is ignored; no state changes.
- Blink counter, each cycle for each slot with half_left!=0 and no load/clear targeting it:
  - div_cnt increments.
  - When div_cnt==BLINK_DIV-1: div_cnt <= 0 and half_left decrements.
- Decode is combinational from registers. A loaded card is visible in seg_bus immediately after the load edge (latency 1 edge).
  - A=0001000, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010.
  - 7=1111000, 8=0000000, 9=0010000, 10 shown as "0"=1000000.
  - J=1100001, Q=0011000, K=0001001.
  - 0, 14 and 15 give blank=1111111.
- Blink masking: a digit is forced blank while half_left is odd.
  - Sequence after a load: shown BLINK_DIV cycles, blank BLINK_DIV cycles, repeated BLINKS times, then steady.
  - Total blink window is 2*BLINKS*BLINK_DIV cycles.
- busy = OR over slots of (half_left!=0).

Optional Feature:
- Macro: CARD7SEG_BANK_SCORE_EN.
- When defined, adds two output ports:
  - score  out  4: Baccarat hand score = (sum of card values over all slots) mod 10.
    - Card values: A=1, 2..9 at face value, 10/J/Q/K=0, invalid=0.
  - score_seg  out  7: score decoded as a digit 0..9 with the 2..9 patterns above, "0"=1000000 and 1=1111001.
- Both score outputs are registered: they update one edge after the card_reg change.
  - They are 0 and 1000000 at reset and after clear.
  - Blink masking does not affect them.
- When not defined, neither port exists and no adder logic is built.

Test Plan (bench with BLINK_DIV=4, BLINKS=2, N_CARDS=6):
- Reset:
  - Stimulus: resetb low mid-run, including during a blink.
  - Required: seg_bus all ones and busy=0 asynchronously; after release, seg_bus stays all ones until a load.
- Sweep:
  - Stimulus: load card 1..13 into slot 0, each followed by waiting until busy=0.
  - Required: the steady seg_bus[6:0] matches every listed pattern. Card 14 → 1111111 with busy never asserting.
- Blink timing:
  - Stimulus: load K into slot 2.
  - Required: seg_bus[20:14] shows K for 4 cycles, blank 4, K 4, blank 4, then steady. busy high for exactly 16 cycles.
- Boundaries:
  - load_idx=6 or 7: no change anywhere.
  - clear and load in the same cycle: all blank, load dropped.
  - Reload of a blinking slot: the blink sequence restarts from "shown".
- Parallel slots:
  - Stimulus: load 5 into slot 0, then 9 into slot 5 two cycles later.
  - Required: independent blink phases offset by 2 cycles; both end steady.
- Score (with CARD7SEG_BANK_SCORE_EN):
  - Stimulus: load 9, 8, Q into slots 0..2.
  - Required: score goes 9 → 7 → 7, score_seg=1111000 one edge after the final load; after clear, score=0.

Source files
------------

// File: rtl/card7seg_bank.sv
// card7seg_bank: N_CARDS registered card slots, one active-low 7-seg digit each.
// Optional hand score outputs when CARD7SEG_BANK_SCORE_EN is defined.
module card7seg_bank #(
  parameter int N_CARDS   = 6,
  parameter int IDX_W     = 3,
  parameter int BLINK_DIV = 25000000,
  parameter int BLINKS    = 2
) (
  input  logic                 slow_clock,
  input  logic                 resetb,
  input  logic                 clear,
  input  logic                 load,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [3:0]           card_in,
`ifdef CARD7SEG_BANK_SCORE_EN
  output logic [3:0]           score,
  output logic [6:0]           score_seg,
`endif
  output logic [7*N_CARDS-1:0] seg_bus,
  output logic                 busy
);

  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HL_W  = $clog2(2 * BLINKS + 2);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);
  localparam logic [HL_W-1:0]  HL_INIT = HL_W'(2 * BLINKS);

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [3:0]       card_q      [N_CARDS];
  logic [3:0]       card_d      [N_CARDS];
  logic [DIV_W-1:0] div_cnt_q   [N_CARDS];
  logic [DIV_W-1:0] div_cnt_d   [N_CARDS];
  logic [HL_W-1:0]  half_left_q [N_CARDS];
  logic [HL_W-1:0]  half_left_d [N_CARDS];

  logic card_ok;

  function automatic logic [6:0] card_seg(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd1:    s = 7'b0001000;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b1000000;
      4'd11:   s = 7'b1100001;
      4'd12:   s = 7'b0011000;
      4'd13:   s = 7'b0001001;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  assign card_ok = (card_in >= 4'd1) && (card_in <= 4'd13);

  // Next state per slot: clear beats load, load restarts the blink.
  always_comb begin
    for (int i = 0; i < N_CARDS; i++) begin
      card_d[i]      = card_q[i];
      div_cnt_d[i]   = div_cnt_q[i];
      half_left_d[i] = half_left_q[i];
      if (clear) begin
        card_d[i]      = '0;
        div_cnt_d[i]   = '0;
        half_left_d[i] = '0;
      end else if (load && (load_idx == IDX_W'(i))) begin
        card_d[i]      = card_in;
        div_cnt_d[i]   = '0;
        half_left_d[i] = card_ok ? HL_INIT : '0;
      end else if (half_left_q[i] != '0) begin
        if (div_cnt_q[i] == DIV_MAX) begin
          div_cnt_d[i]   = '0;
          half_left_d[i] = half_left_q[i] - HL_W'(1);
        end else begin
          div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Slot registers.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < N_CARDS; i++) begin
        card_q[i]      <= '0;
        div_cnt_q[i]   <= '0;
        half_left_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CARDS; i++) begin
        card_q[i]      <= card_d[i];
        div_cnt_q[i]   <= div_cnt_d[i];
        half_left_q[i] <= half_left_d[i];
      end
    end
  end

  // Digit decode with blanking on odd half-periods; busy while any slot blinks.
  always_comb begin
    seg_bus = '1;
    busy    = 1'b0;
    for (int i = 0; i < N_CARDS; i++) begin
      if (half_left_q[i][0]) begin
        seg_bus[7*i +: 7] = BLANK;
      end else begin
        seg_bus[7*i +: 7] = card_seg(card_q[i]);
      end
      busy = busy | (half_left_q[i] != '0);
    end
  end

`ifdef CARD7SEG_BANK_SCORE_EN
  localparam int SUM_W = $clog2(9 * N_CARDS + 1);

  logic [SUM_W-1:0] sum;
  logic [3:0]       score_d;
  logic [3:0]       score_q;
  logic [6:0]       score_seg_d;
  logic [6:0]       score_seg_q;

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      default: s = card_seg(d);
    endcase
    return s;
  endfunction

  // Baccarat score of the current hand, one edge behind the slots.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      sum = sum + SUM_W'(card_val(card_q[i]));
    end
    score_d     = clear ? 4'd0 : 4'(sum % 10);
    score_seg_d = digit_seg(score_d);
  end

  // Score registers.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      score_q     <= '0;
      score_seg_q <= 7'b1000000;
    end else begin
      score_q     <= score_d;
      score_seg_q <= score_seg_d;
    end
  end

  assign score     = score_q;
  assign score_seg = score_seg_q;
`endif

endmodule
